// File: rtl/nabp_fill_process_scheduler_if.sv
// Bundles the host, addresser, filter and processing handshakes of the fill/process scheduler.
interface nabp_fill_process_scheduler_if #(
    parameter int unsigned kAngleLength = 8
);
    localparam int unsigned AngW = kAngleLength;

    logic            hs_kick;
    logic            hs_done;
    logic [AngW-1:0] sa_angle;
    logic            sa_has_next_angle;
    logic            sa_next_angle;
    logic            fl_kick;
    logic            fl_bank;
    logic [AngW-1:0] fl_angle;
    logic            fl_done;
    logic            pr_kick;
    logic            pr_bank;
    logic [AngW-1:0] pr_angle;
    logic            pr_done;

    // Scheduler side
    modport master (
        input  hs_kick, sa_angle, sa_has_next_angle, fl_done, pr_done,
        output hs_done, sa_next_angle, fl_kick, fl_bank, fl_angle,
               pr_kick, pr_bank, pr_angle
    );

    // Host / addresser / filter / processing side
    modport slave (
        output hs_kick, sa_angle, sa_has_next_angle, fl_done, pr_done,
        input  hs_done, sa_next_angle, fl_kick, fl_bank, fl_angle,
               pr_kick, pr_bank, pr_angle
    );
endinterface

// File: rtl/nabp_fill_process_scheduler.sv
// Ping-pong scheduler for the two-bank filtered RAM: one bank fills with the
// next angle while the other is processed, angles consumed strictly in order.
module nabp_fill_process_scheduler #(
    parameter int unsigned kAngleLength = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    nabp_fill_process_scheduler_if.master bus_io
);
    localparam int unsigned AngW = kAngleLength;

    typedef enum logic {idle_s, run_s} state_e;
    typedef enum logic [1:0] {bank_empty, bank_filling, bank_full, bank_busy} bank_st_e;

    state_e          state_q, state_d;
    bank_st_e        bank_st_q  [2];
    bank_st_e        bank_st_d  [2];
    logic [AngW-1:0] bank_ang_q [2];
    logic [AngW-1:0] bank_ang_d [2];
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic            fill_out_q, fill_out_d;
    logic            proc_out_q, proc_out_d;
    logic            exhausted_q, exhausted_d;
    logic            primed_q, primed_d;

    logic            hs_done_q, hs_done_d;
    logic            sa_next_q, sa_next_d;
    logic            fl_kick_q, fl_kick_d;
    logic            fl_bank_q, fl_bank_d;
    logic [AngW-1:0] fl_angle_q, fl_angle_d;
    logic            pr_kick_q, pr_kick_d;
    logic            pr_bank_q, pr_bank_d;
    logic [AngW-1:0] pr_angle_q, pr_angle_d;

    // State, bank bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= idle_s;
            for (int i = 0; i < 2; i++) begin
                bank_st_q[i]  <= bank_empty;
                bank_ang_q[i] <= '0;
            end
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            fill_out_q  <= 1'b0;
            proc_out_q  <= 1'b0;
            exhausted_q <= 1'b0;
            primed_q    <= 1'b0;
            hs_done_q   <= 1'b0;
            sa_next_q   <= 1'b0;
            fl_kick_q   <= 1'b0;
            fl_bank_q   <= 1'b0;
            fl_angle_q  <= '0;
            pr_kick_q   <= 1'b0;
            pr_bank_q   <= 1'b0;
            pr_angle_q  <= '0;
        end else begin
            state_q     <= state_d;
            bank_st_q   <= bank_st_d;
            bank_ang_q  <= bank_ang_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            fill_out_q  <= fill_out_d;
            proc_out_q  <= proc_out_d;
            exhausted_q <= exhausted_d;
            primed_q    <= primed_d;
            hs_done_q   <= hs_done_d;
            sa_next_q   <= sa_next_d;
            fl_kick_q   <= fl_kick_d;
            fl_bank_q   <= fl_bank_d;
            fl_angle_q  <= fl_angle_d;
            pr_kick_q   <= pr_kick_d;
            pr_bank_q   <= pr_bank_d;
            pr_angle_q  <= pr_angle_d;
        end
    end

    // Next-state: fill and process issue/retire can all happen in one cycle
    // because they always touch different banks (FILLING vs BUSY/FULL/EMPTY).
    always_comb begin
        state_d     = state_q;
        bank_st_d   = bank_st_q;
        bank_ang_d  = bank_ang_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        fill_out_d  = fill_out_q;
        proc_out_d  = proc_out_q;
        exhausted_d = exhausted_q;
        primed_d    = primed_q;
        hs_done_d   = 1'b0;
        sa_next_d   = 1'b0;
        fl_kick_d   = 1'b0;
        fl_bank_d   = fl_bank_q;
        fl_angle_d  = fl_angle_q;
        pr_kick_d   = 1'b0;
        pr_bank_d   = pr_bank_q;
        pr_angle_d  = pr_angle_q;

        case (state_q)
            idle_s: begin
                if (bus_io.hs_kick) begin
                    state_d      = run_s;
                    sa_next_d    = 1'b1;
                    primed_d     = 1'b1;
                    bank_st_d[0] = bank_empty;
                    bank_st_d[1] = bank_empty;
                    wr_bank_d    = 1'b0;
                    rd_bank_d    = 1'b0;
                    fill_out_d   = 1'b0;
                    proc_out_d   = 1'b0;
                    exhausted_d  = 1'b0;
                end
            end
            run_s: begin
                // Fill waits one cycle after any addresser advance so sa_angle has settled
                if (primed_q && !fill_out_q && !exhausted_q &&
                    bank_st_q[wr_bank_q] == bank_empty && !sa_next_q) begin
                    fl_kick_d             = 1'b1;
                    fl_bank_d             = wr_bank_q;
                    fl_angle_d            = bus_io.sa_angle;
                    bank_st_d[wr_bank_q]  = bank_filling;
                    bank_ang_d[wr_bank_q] = bus_io.sa_angle;
                    fill_out_d            = 1'b1;
                end
                if (fill_out_q && bus_io.fl_done) begin
                    bank_st_d[wr_bank_q] = bank_full;
                    wr_bank_d            = ~wr_bank_q;
                    fill_out_d           = 1'b0;
                    if (bus_io.sa_has_next_angle) begin
                        sa_next_d = 1'b1;
                    end else begin
                        exhausted_d = 1'b1;
                    end
                end
                if (!proc_out_q && bank_st_q[rd_bank_q] == bank_full) begin
                    pr_kick_d            = 1'b1;
                    pr_bank_d            = rd_bank_q;
                    pr_angle_d           = bank_ang_q[rd_bank_q];
                    bank_st_d[rd_bank_q] = bank_busy;
                    proc_out_d           = 1'b1;
                end
                if (proc_out_q && bus_io.pr_done) begin
                    bank_st_d[rd_bank_q] = bank_empty;
                    rd_bank_d            = ~rd_bank_q;
                    proc_out_d           = 1'b0;
                end
                if (exhausted_q && !fill_out_q && !proc_out_q &&
                    bank_st_q[0] == bank_empty && bank_st_q[1] == bank_empty) begin
                    hs_done_d = 1'b1;
                    primed_d  = 1'b0;
                    state_d   = idle_s;
                end
            end
            default: state_d = idle_s;
        endcase
    end

    assign bus_io.hs_done       = hs_done_q;
    assign bus_io.sa_next_angle = sa_next_q;
    assign bus_io.fl_kick       = fl_kick_q;
    assign bus_io.fl_bank       = fl_bank_q;
    assign bus_io.fl_angle      = fl_angle_q;
    assign bus_io.pr_kick       = pr_kick_q;
    assign bus_io.pr_bank       = pr_bank_q;
    assign bus_io.pr_angle      = pr_angle_q;
endmodule

// File: tb/tb_nabp_fill_process_scheduler.sv
// Bench for the fill/process scheduler: addresser and done responders,
// a counter-based reference model checked every cycle, and literal run checks.
module tb_nabp_fill_process_scheduler;
    localparam int unsigned AW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    nabp_fill_process_scheduler_if #(.kAngleLength(AW)) bus ();

    nabp_fill_process_scheduler #(.kAngleLength(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Run configuration
    int ang [4];
    int n_ang  = 3;
    int fl_lat = 1;
    int pr_lat = 1;

    // Requests from the directed sequence, consumed by the environment
    int rst_cnt   = 3;
    bit kick_req  = 0;
    bit spur_fl   = 0;
    bit spur_pr   = 0;
    bit spur_kick = 0;

    // Environment state
    int cyc      = 0;
    int pos      = -1;
    bit adv_pend = 0;
    int fl_cnt   = 0;
    int pr_cnt   = 0;

    // Per-run logs of DUT activity
    int fl_n = 0, pr_n = 0, sa_n = 0, done_n = 0, pd_n = 0, both_n = 0;
    int kick_cyc = 0, done_t = 0;
    int fl_b [8], fl_a [8], fl_t [8];
    int pr_b [8], pr_a [8];
    int pd_t [8];

    // Reference model: counts of fills/processes issued and retired
    bit m_run = 0, m_exh = 0;
    int m_fi = 0, m_fd = 0, m_pi = 0, m_pd = 0;
    bit e_done = 0, e_sa = 0, e_flk = 0, e_flb = 0, e_prk = 0, e_prb = 0;
    logic [AW-1:0] e_fla = '0, e_pra = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bank k%2 gets fill k; a bank is free once the fill two earlier was processed.
    task automatic model_step(input bit rs, input bit kick, input bit fd, input bit pd);
        bit cur_sa, fill_out, proc_out, can_fill, can_proc, fin;
        cur_sa = e_sa;
        e_done = 0; e_sa = 0; e_flk = 0; e_prk = 0;
        if (rs) begin
            m_run = 0; m_exh = 0;
            m_fi = 0; m_fd = 0; m_pi = 0; m_pd = 0;
            e_flb = 0; e_fla = '0; e_prb = 0; e_pra = '0;
        end else if (!m_run) begin
            if (kick) begin
                m_run = 1; m_exh = 0;
                m_fi = 0; m_fd = 0; m_pi = 0; m_pd = 0;
                e_sa = 1;
            end
        end else begin
            fill_out = (m_fi > m_fd);
            proc_out = (m_pi > m_pd);
            can_fill = !fill_out && !m_exh && (m_fi - m_pd <= 1) && !cur_sa;
            can_proc = !proc_out && (m_pi < m_fd);
            fin      = m_exh && !fill_out && !proc_out && (m_pd == m_fd);
            if (can_fill) begin
                e_flk = 1; e_flb = 1'(m_fi % 2); e_fla = AW'(ang[m_fi]);
                m_fi++;
            end
            if (fill_out && fd) begin
                if (m_fd < n_ang - 1) e_sa = 1;
                else m_exh = 1;
                m_fd++;
            end
            if (can_proc) begin
                e_prk = 1; e_prb = 1'(m_pi % 2); e_pra = AW'(ang[m_pi]);
                m_pi++;
            end
            if (proc_out && pd) m_pd++;
            if (fin) begin
                e_done = 1; m_run = 0;
            end
        end
    endtask

    // Compare, log, drive this cycle's inputs, then advance the model
    always @(negedge clk) begin
        bit rs, kk, sk, fd, pd;
        cyc++;
        chk("hs_done",       bus.hs_done,       e_done);
        chk("sa_next_angle", bus.sa_next_angle, e_sa);
        chk("fl_kick",       bus.fl_kick,       e_flk);
        chk("fl_bank",       bus.fl_bank,       e_flb);
        chk("fl_angle",      bus.fl_angle,      e_fla);
        chk("pr_kick",       bus.pr_kick,       e_prk);
        chk("pr_bank",       bus.pr_bank,       e_prb);
        chk("pr_angle",      bus.pr_angle,      e_pra);

        if (bus.fl_kick === 1'b1 && fl_n < 8) begin
            fl_b[fl_n] = bus.fl_bank; fl_a[fl_n] = bus.fl_angle; fl_t[fl_n] = cyc; fl_n++;
        end
        if (bus.pr_kick === 1'b1 && pr_n < 8) begin
            pr_b[pr_n] = bus.pr_bank; pr_a[pr_n] = bus.pr_angle; pr_n++;
        end
        if (bus.sa_next_angle === 1'b1) sa_n++;
        if (bus.hs_done === 1'b1) begin
            done_n++; done_t = cyc;
        end

        rs = (rst_cnt > 0);
        if (rst_cnt > 0) rst_cnt--;
        kk = kick_req;  kick_req  = 0;
        sk = spur_kick; spur_kick = 0;

        // Addresser: advance takes effect the cycle after the pulse
        if (adv_pend) pos++;
        adv_pend = (bus.sa_next_angle === 1'b1);
        if (kk) begin
            kick_cyc = cyc; pos = -1; adv_pend = 0;
        end

        // Filter / processing responders
        fd = 0; pd = 0;
        if (fl_cnt > 0) begin fl_cnt--; if (fl_cnt == 0) fd = 1; end
        if (bus.fl_kick === 1'b1) fl_cnt = fl_lat;
        if (pr_cnt > 0) begin pr_cnt--; if (pr_cnt == 0) pd = 1; end
        if (bus.pr_kick === 1'b1) pr_cnt = pr_lat;
        if (rs) begin fl_cnt = 0; pr_cnt = 0; fd = 0; pd = 0; end
        if (pd && pd_n < 8) begin pd_t[pd_n] = cyc; pd_n++; end
        if (fd && pd) both_n++;
        fd = fd | spur_fl; spur_fl = 0;
        pd = pd | spur_pr; spur_pr = 0;

        reset     = rs;
        bus.hs_kick = kk | sk;
        bus.fl_done = fd;
        bus.pr_done = pd;
        if (pos >= 0 && pos < n_ang) bus.sa_angle = AW'(ang[pos]);
        else                         bus.sa_angle = 8'hFF;
        bus.sa_has_next_angle = (pos + 1 < n_ang);

        model_step(rs, kk | sk, fd, pd);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        fl_n = 0; pr_n = 0; sa_n = 0; done_n = 0; pd_n = 0; both_n = 0;
        kick_req = 1;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_n == 0 && k < budget) begin
            wait_cyc(1);
            k++;
        end
        chk("done_within_budget", 32'(done_n > 0), 1);
        wait_cyc(4);
    endtask

    task automatic chk_three_in_order(input string tag);
        int ea [3];
        int eb [3];
        ea = '{0, 60, 120};
        eb = '{0, 1, 0};
        chk({tag, "_fl_count"}, fl_n, 3);
        chk({tag, "_pr_count"}, pr_n, 3);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_fl_angle_seq"}, fl_a[i], ea[i]);
            chk({tag, "_fl_bank_seq"},  fl_b[i], eb[i]);
            chk({tag, "_pr_angle_seq"}, pr_a[i], ea[i]);
            chk({tag, "_pr_bank_seq"},  pr_b[i], eb[i]);
        end
        chk({tag, "_sa_pulses"}, sa_n, 3);
        chk({tag, "_done_pulses"}, done_n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ang = '{0, 60, 120, 0};
        wait_cyc(5);

        // Fast fill and processing
        n_ang = 3; fl_lat = 1; pr_lat = 1;
        start_run();
        wait_done(200);
        chk_three_in_order("fast");
        chk("fast_first_fl_latency", fl_t[0] - kick_cyc, 3);
        chk("fast_done_latency", done_t - kick_cyc, 17);

        // Slow processing: third fill waits for bank 0 to be freed
        pr_lat = 20;
        start_run();
        wait_done(300);
        chk_three_in_order("slow");
        chk("slow_second_fill_before_free", 32'(fl_t[1] < pd_t[0]), 1);
        chk("slow_third_fill_after_free", fl_t[2], pd_t[0] + 2);

        // fl_done and pr_done land in the same cycle
        fl_lat = 1; pr_lat = 2;
        start_run();
        wait_done(200);
        chk_three_in_order("coincident");
        chk("coincident_seen", 32'(both_n > 0), 1);

        // Single angle
        ang = '{45, 0, 0, 0}; n_ang = 1; pr_lat = 1;
        start_run();
        wait_done(200);
        wait_cyc(5);
        chk("single_fl_count", fl_n, 1);
        chk("single_fl_angle", fl_a[0], 45);
        chk("single_pr_count", pr_n, 1);
        chk("single_pr_angle", pr_a[0], 45);
        chk("single_sa_pulses", sa_n, 1);
        chk("single_done_pulses", done_n, 1);

        // Reset mid-run with bank 0 busy and bank 1 full
        ang = '{0, 60, 120, 0}; n_ang = 3; pr_lat = 20;
        start_run();
        wait_cyc(12);
        chk("midrun_fl_count", fl_n, 2);
        chk("midrun_pr_count", pr_n, 1);
        rst_cnt = 1;
        wait_cyc(1);
        chk("rst_hs_done",  bus.hs_done, 0);
        chk("rst_sa_next",  bus.sa_next_angle, 0);
        chk("rst_fl_kick",  bus.fl_kick, 0);
        chk("rst_fl_bank",  bus.fl_bank, 0);
        chk("rst_fl_angle", bus.fl_angle, 0);
        chk("rst_pr_kick",  bus.pr_kick, 0);
        chk("rst_pr_bank",  bus.pr_bank, 0);
        chk("rst_pr_angle", bus.pr_angle, 0);
        wait_cyc(3);
        chk("rst_no_done", done_n, 0);
        pr_lat = 1;
        start_run();
        wait_done(200);
        chk_three_in_order("restart");
        chk("restart_first_fl_latency", fl_t[0] - kick_cyc, 3);

        // Spurious pr_done, fl_done and hs_kick while running
        fl_lat = 1; pr_lat = 20;
        start_run();
        wait_cyc(4);
        spur_pr = 1;
        wait_cyc(11);
        spur_fl = 1; spur_kick = 1;
        wait_done(300);
        chk_three_in_order("spurious");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
